// File: rtl/tl_inflight_tracker.sv
// Per-source TileLink A/D in-flight tracker with sticky first-error capture and a no-progress watchdog.
// Latency: count, watchdog and error outputs are registered and update the cycle after the causing fire.
// Backpressure: observe-only; it never drives a_ready/d_ready and reacts to fired beats only.
module tl_inflight_tracker #(
    parameter int SOURCE_BITS     = 4,
    parameter int SIZE_BITS       = 3,
    parameter int BEAT_BYTES_LOG2 = 3,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SOURCE_BITS-1:0] d_source,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic                   err_clear,
    output logic [SOURCE_BITS:0]   inflight_count,
    output logic                   err_valid,
    output logic [2:0]             err_code,
    output logic [SOURCE_BITS-1:0] err_source
);
    localparam int N       = 2 ** SOURCE_BITS;
    localparam int MAX_LOG = 2 ** SIZE_BITS - 1 - BEAT_BYTES_LOG2;
    localparam int CW      = (MAX_LOG > 0) ? MAX_LOG : 1;
    localparam int WW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_PRE = WW'(TIMEOUT_CYCLES - 1);

    function automatic logic [CW-1:0] last_beat(input logic [SIZE_BITS-1:0] size, input logic has_data);
        int beats_m1;
        beats_m1 = 0;
        if (has_data && int'(size) > BEAT_BYTES_LOG2)
            beats_m1 = (1 << (int'(size) - BEAT_BYTES_LOG2)) - 1;
        return beats_m1[CW-1:0];
    endfunction

    logic                   a_fire, d_fire;
    logic [CW-1:0]          a_cnt, d_cnt;
    logic                   a_first, a_last, d_first, d_last;
    logic                   a_op_bad, a_alloc, d_free;
    logic [1:0]             a_exp_op;
    logic [N-1:0]           ent_vld, ent_vld_nxt;
    logic [SIZE_BITS-1:0]   ent_size [N];
    logic [1:0]             ent_op   [N];
    logic [SOURCE_BITS:0]   count_nxt;
    logic [WW-1:0]          wd_cnt;
    logic                   wd_hit;
    logic                   e_dup, e_noreq, e_op, e_size;
    logic [2:0]             new_code;
    logic [SOURCE_BITS-1:0] new_src;

    assign a_fire   = a_valid & a_ready;
    assign d_fire   = d_valid & d_ready;
    assign a_first  = (a_cnt == '0);
    assign d_first  = (d_cnt == '0);
    assign a_last   = (a_cnt == last_beat(a_size, a_opcode <= 3'd3));
    assign d_last   = (d_cnt == last_beat(d_size, d_opcode == 3'd1));
    assign a_op_bad = (a_opcode >= 3'd6);
    assign a_alloc  = a_fire & a_first & ~a_op_bad;
    assign d_free   = d_fire & d_last;

    always_comb begin
        a_exp_op = 2'd1;
        if (a_opcode <= 3'd1)
            a_exp_op = 2'd0;
        else if (a_opcode == 3'd5)
            a_exp_op = 2'd2;
    end

    // Free before allocate so a same-cycle last D beat and new A request on one source keeps it valid.
    always_comb begin
        ent_vld_nxt = ent_vld;
        if (d_free)
            ent_vld_nxt[d_source] = 1'b0;
        if (a_alloc)
            ent_vld_nxt[a_source] = 1'b1;
        count_nxt = '0;
        for (int i = 0; i < N; i++)
            count_nxt = count_nxt + {{SOURCE_BITS{1'b0}}, ent_vld_nxt[i]};
    end

    assign e_dup   = a_alloc & ent_vld[a_source] & ~(d_free & (d_source == a_source));
    assign e_noreq = d_fire & d_first & ~ent_vld[d_source];
    assign e_op    = d_fire & d_first & ent_vld[d_source] & (d_opcode != {1'b0, ent_op[d_source]});
    assign e_size  = d_fire & d_first & ent_vld[d_source] & (d_size != ent_size[d_source]);
    assign wd_hit  = ~d_fire & (inflight_count != '0) & (wd_cnt == WD_PRE);

    // Later assignments override earlier ones, so the lowest code present wins.
    always_comb begin
        new_code = 3'd0;
        new_src  = '0;
        if (wd_hit) begin
            new_code = 3'd6;
            new_src  = '0;
        end
        if (a_fire & a_first & a_op_bad) begin
            new_code = 3'd5;
            new_src  = a_source;
        end
        if (e_size) begin
            new_code = 3'd4;
            new_src  = d_source;
        end
        if (e_op) begin
            new_code = 3'd3;
            new_src  = d_source;
        end
        if (e_noreq) begin
            new_code = 3'd2;
            new_src  = d_source;
        end
        if (e_dup) begin
            new_code = 3'd1;
            new_src  = a_source;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_cnt          <= '0;
            d_cnt          <= '0;
            ent_vld        <= '0;
            for (int i = 0; i < N; i++) begin
                ent_size[i] <= '0;
                ent_op[i]   <= '0;
            end
            inflight_count <= '0;
            wd_cnt         <= '0;
            err_valid      <= 1'b0;
            err_code       <= 3'd0;
            err_source     <= '0;
        end else begin
            if (a_fire)
                a_cnt <= a_last ? '0 : a_cnt + 1'b1;
            if (d_fire)
                d_cnt <= d_last ? '0 : d_cnt + 1'b1;
            ent_vld <= ent_vld_nxt;
            if (a_alloc) begin
                ent_size[a_source] <= a_size;
                ent_op[a_source]   <= a_exp_op;
            end
            inflight_count <= count_nxt;
            if (d_fire || inflight_count == '0)
                wd_cnt <= '0;
            else if (wd_cnt != WD_MAX)
                wd_cnt <= wd_cnt + 1'b1;
            if (err_clear) begin
                err_valid  <= 1'b0;
                err_code   <= 3'd0;
                err_source <= '0;
            end else if (!err_valid && new_code != 3'd0) begin
                err_valid  <= 1'b1;
                err_code   <= new_code;
                err_source <= new_src;
            end
        end
    end
endmodule
